// File: rtl/keccak_axis_deadlock_detector.sv
// Deadlock detector for the keccak_top HLS kernel: watches registered AXIS blocking,
// idle and internal-block probes, and latches a sticky block flag after a sustained stall.
module keccak_axis_deadlock_detector #(
   parameter int NUM_AXIS     = 2,
   parameter int NUM_INST     = 3,
   parameter int NUM_BLK      = 1,
   parameter int STALL_CYCLES = 64,
   parameter int CNT_W        = 16
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [NUM_AXIS-1:0] axis_block_sigs,
   input  logic [NUM_INST-1:0] inst_idle_sigs,
   input  logic [NUM_BLK-1:0]  inst_block_sigs,
   output logic                block,
   output logic                suspect,
   output logic [NUM_AXIS-1:0] block_chan_mask,
   output logic [CNT_W-1:0]    abort_count
);

   localparam int CW = $clog2(STALL_CYCLES + 1);
   localparam logic [CW-1:0] TERMINAL = CW'(STALL_CYCLES - 1);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_SUSPECT  = 2'd1;
   localparam logic [1:0] ST_DEADLOCK = 2'd2;

   logic [NUM_AXIS-1:0] axis_q;
   logic [NUM_INST-1:0] idle_q;
   logic [NUM_BLK-1:0]  iblk_q;
   logic [NUM_AXIS-1:0] stalled;
   logic [NUM_AXIS-1:0] stuck;
   logic                cond;
   logic [1:0]          state;
   logic [CW-1:0]       cnt;
   logic                unused_top_idle;

   // The top-level idle slot carries no information about a channel.
   assign unused_top_idle = idle_q[0];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         axis_q <= '0;
         idle_q <= '0;
         iblk_q <= '0;
      end else begin
         axis_q <= axis_block_sigs;
         idle_q <= inst_idle_sigs;
         iblk_q <= inst_block_sigs;
      end
   end

   // Channel i maps to instance i+1; a channel is stuck if its owner is idle or it is blocked.
   always_comb begin
      stalled = '0;
      stuck   = '0;
      for (int i = 0; i < NUM_AXIS; i++) begin
         stalled[i] = axis_q[i] & ~idle_q[i+1];
         stuck[i]   = idle_q[i+1] | axis_q[i];
      end
      cond = (&stuck) & ((|stalled) | (|iblk_q));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= ST_RUN;
         cnt             <= '0;
         block_chan_mask <= '0;
         abort_count     <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (cond) begin
                  state <= ST_SUSPECT;
                  cnt   <= CW'(1);
               end else begin
                  cnt   <= '0;
               end
            end
            ST_SUSPECT: begin
               // A dropped condition beats the terminal count.
               if (!cond) begin
                  state <= ST_RUN;
                  cnt   <= '0;
                  if (abort_count != {CNT_W{1'b1}})
                     abort_count <= abort_count + 1'b1;
               end else if (cnt == TERMINAL) begin
                  state           <= ST_DEADLOCK;
                  block_chan_mask <= stalled;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DEADLOCK: begin
               state <= ST_DEADLOCK;
            end
            default: begin
               state <= ST_RUN;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign block   = (state == ST_DEADLOCK);
   assign suspect = (state == ST_SUSPECT);

endmodule

// File: tb/tb_keccak_axis_deadlock_detector.sv
// Directed-vector bench for keccak_axis_deadlock_detector with a 4-cycle stall window
// and a 4-bit abort counter so saturation is reachable quickly.
module tb_keccak_axis_deadlock_detector;

   logic       clock;
   logic       reset_n;
   logic [1:0] axis_block_sigs;
   logic [2:0] inst_idle_sigs;
   logic [0:0] inst_block_sigs;
   logic       block;
   logic       suspect;
   logic [1:0] block_chan_mask;
   logic [3:0] abort_count;

   int comp_count = 0;
   int mism_count = 0;

   keccak_axis_deadlock_detector #(
      .NUM_AXIS     (2),
      .NUM_INST     (3),
      .NUM_BLK      (1),
      .STALL_CYCLES (4),
      .CNT_W        (4)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .axis_block_sigs (axis_block_sigs),
      .inst_idle_sigs  (inst_idle_sigs),
      .inst_block_sigs (inst_block_sigs),
      .block           (block),
      .suspect         (suspect),
      .block_chan_mask (block_chan_mask),
      .abort_count     (abort_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      comp_count++;
      if (observed !== expected) begin
         mism_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Inputs change on the falling edge so the next rising edge samples them cleanly.
   task automatic applyStimulus(input logic [1:0] axis, input logic [2:0] idle,
                                input logic iblk);
      @(negedge clock);
      axis_block_sigs = axis;
      inst_idle_sigs  = idle;
      inst_block_sigs = iblk;
   endtask

   task automatic stepEdges(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Starts 1 time unit after a rising edge; releases reset before the next one.
   task automatic pulseReset();
      #2 reset_n = 1'b0;
      #1;
      checkOutput("rst_block", 32'(block), 32'd0);
      checkOutput("rst_suspect", 32'(suspect), 32'd0);
      checkOutput("rst_mask", 32'(block_chan_mask), 32'd0);
      checkOutput("rst_abort", 32'(abort_count), 32'd0);
      #2 reset_n = 1'b1;
   endtask

   initial begin
      reset_n         = 1'b0;
      axis_block_sigs = '0;
      inst_idle_sigs  = '0;
      inst_block_sigs = '0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      // Idle kernel with all probes low.
      for (int k = 0; k < 10; k++) begin
         stepEdges(10);
         checkOutput("quiet_block", 32'(block), 32'd0);
         checkOutput("quiet_suspect", 32'(suspect), 32'd0);
      end
      checkOutput("quiet_abort", 32'(abort_count), 32'd0);

      // Channel 0 stalled against a busy instance 1 while instance 2 is idle.
      applyStimulus(2'b01, 3'b100, 1'b0);
      stepEdges(1);
      checkOutput("stall_e0_suspect", 32'(suspect), 32'd0);
      stepEdges(1);
      checkOutput("stall_e1_suspect", 32'(suspect), 32'd1);
      checkOutput("stall_e1_block", 32'(block), 32'd0);
      stepEdges(2);
      checkOutput("stall_e3_block", 32'(block), 32'd0);
      checkOutput("stall_e3_suspect", 32'(suspect), 32'd1);
      stepEdges(1);
      checkOutput("stall_e4_block", 32'(block), 32'd1);
      checkOutput("stall_e4_suspect", 32'(suspect), 32'd0);
      checkOutput("stall_e4_mask", 32'(block_chan_mask), 32'd1);
      applyStimulus(2'b00, 3'b000, 1'b0);
      stepEdges(10);
      checkOutput("sticky_block", 32'(block), 32'd1);
      checkOutput("sticky_mask", 32'(block_chan_mask), 32'd1);
      checkOutput("sticky_abort", 32'(abort_count), 32'd0);

      pulseReset();

      // Three stalled samples, then channel 1 frees up; the drop meets the terminal count.
      applyStimulus(2'b11, 3'b000, 1'b0);
      stepEdges(1);
      stepEdges(1);
      checkOutput("abort_e1_suspect", 32'(suspect), 32'd1);
      stepEdges(1);
      applyStimulus(2'b01, 3'b000, 1'b0);
      stepEdges(1);
      checkOutput("abort_e3_suspect", 32'(suspect), 32'd1);
      checkOutput("abort_e3_count", 32'(abort_count), 32'd0);
      stepEdges(1);
      checkOutput("abort_e4_suspect", 32'(suspect), 32'd0);
      checkOutput("abort_e4_block", 32'(block), 32'd0);
      checkOutput("abort_e4_count", 32'(abort_count), 32'd1);

      // Busy, unblocked channel 1 keeps the condition false indefinitely.
      for (int k = 0; k < 20; k++) begin
         stepEdges(10);
         checkOutput("busy_block", 32'(block), 32'd0);
         checkOutput("busy_suspect", 32'(suspect), 32'd0);
      end
      checkOutput("busy_abort", 32'(abort_count), 32'd1);

      // Internal instance block with both channel owners idle.
      applyStimulus(2'b00, 3'b110, 1'b1);
      stepEdges(1);
      stepEdges(3);
      checkOutput("iblk_e3_block", 32'(block), 32'd0);
      checkOutput("iblk_e3_suspect", 32'(suspect), 32'd1);
      stepEdges(1);
      checkOutput("iblk_e4_block", 32'(block), 32'd1);
      checkOutput("iblk_e4_mask", 32'(block_chan_mask), 32'd0);

      // Reset out of DEADLOCK, inputs still stuck: full window needed again.
      pulseReset();
      stepEdges(1);
      checkOutput("redet_e0_suspect", 32'(suspect), 32'd0);
      stepEdges(1);
      checkOutput("redet_e1_suspect", 32'(suspect), 32'd1);
      stepEdges(2);
      checkOutput("redet_e3_block", 32'(block), 32'd0);
      stepEdges(1);
      checkOutput("redet_e4_block", 32'(block), 32'd1);

      // Repeated one-cycle suspicions drive the abort counter into saturation.
      pulseReset();
      for (int i = 1; i <= 19; i++) begin
         applyStimulus(2'b01, 3'b100, 1'b0);
         stepEdges(1);
         applyStimulus(2'b00, 3'b000, 1'b0);
         stepEdges(2);
         if (i == 1)  checkOutput("sat_1", 32'(abort_count), 32'd1);
         if (i == 14) checkOutput("sat_14", 32'(abort_count), 32'd14);
         if (i == 15) checkOutput("sat_15", 32'(abort_count), 32'd15);
         if (i == 19) checkOutput("sat_19", 32'(abort_count), 32'd15);
      end
      checkOutput("sat_block", 32'(block), 32'd0);
      checkOutput("sat_suspect", 32'(suspect), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_count, mism_count);
      $finish;
   end

endmodule
